// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_operand_stage
// Purpose  : ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding,
//            load-use / result-not-ready hazard detection and bubble insertion.
//            Optional: ID_EX_PERF_CNT_EN adds perf_bubbles / perf_fwd counters.
// Revision : 1.0
// ============================================================================
module id_ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rs3,
    input  logic [2:0]        id_use,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wr_en,
    input  logic              id_mem_read,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    input  logic [DATA_W-1:0] rf_rd3,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_wr_en,
    input  logic              mem_is_load,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_wr_en,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    output logic [DATA_W-1:0] ex_op3,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_wr_en,
    output logic              ex_mem_read,
`ifdef ID_EX_PERF_CNT_EN
    output logic [31:0]       perf_bubbles,
    output logic [31:0]       perf_fwd,
`endif
    output logic [CTRL_W-1:0] ex_ctrl
);

    // r15 is the all-ones index; like r0 it is never a forwarding/hazard target
    localparam logic [REG_AW-1:0] REG_TOP = '1;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } state_t;

    state_t state, state_next;

    logic [2:0][REG_AW-1:0] rs_vec;
    logic [2:0][DATA_W-1:0] rf_vec;
    logic [2:0][DATA_W-1:0] op_res;
    logic [2:0]             trackable;
    logic [2:0]             fwd_mem;
    logic [2:0]             fwd_wb;
    logic [2:0]             haz_src;
    logic                   hazard;
    logic                   fwd_any;
    logic                   take_bubble;
    logic                   advance;

    assign rs_vec = {id_rs3, id_rs2, id_rs1};
    assign rf_vec = {rf_rd3, rf_rd2, rf_rd1};

    generate
        for (genvar i = 0; i < 3; i++) begin : g_src
            assign trackable[i] = (rs_vec[i] != '0) && (rs_vec[i] != REG_TOP);
            assign fwd_mem[i]   = trackable[i] && mem_wr_en && !mem_is_load && (mem_rd == rs_vec[i]);
            assign fwd_wb[i]    = trackable[i] && wb_wr_en && (wb_rd == rs_vec[i]);
            // EX/MEM is the younger producer and wins over MEM/WB
            assign op_res[i]    = fwd_mem[i] ? mem_result :
                                  fwd_wb[i]  ? wb_data    : rf_vec[i];
            assign haz_src[i]   = id_use[i] && trackable[i] &&
                                  ((ex_valid && ex_wr_en && (ex_rd == rs_vec[i])) ||
                                   (mem_wr_en && mem_is_load && (mem_rd == rs_vec[i])));
        end
    endgenerate

    assign hazard  = id_valid && (|haz_src);
    assign fwd_any = |(fwd_mem | fwd_wb);

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    always_comb begin
        state_next  = state;
        stall_id    = 1'b0;
        take_bubble = 1'b0;
        advance     = 1'b0;
        if (rst) begin
            state_next = RUN;
        end else if (flush) begin
            state_next = RUN;
        end else if (ex_hold) begin
            stall_id = 1'b1;
        end else if (hazard) begin
            stall_id    = 1'b1;
            take_bubble = 1'b1;
            state_next  = BUBBLE;
        end else begin
            advance    = 1'b1;
            state_next = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_op1      <= '0;
            ex_op2      <= '0;
            ex_op3      <= '0;
            ex_rd       <= '0;
            ex_wr_en    <= 1'b0;
            ex_mem_read <= 1'b0;
            ex_ctrl     <= '0;
        end else if (flush) begin
            ex_valid    <= 1'b0;
            ex_wr_en    <= 1'b0;
            ex_mem_read <= 1'b0;
            ex_ctrl     <= '0;
        end else if (ex_hold) begin
            ex_valid    <= ex_valid;
        end else if (take_bubble || (advance && !id_valid)) begin
            // an empty ID slot advances exactly like an inserted bubble
            ex_valid    <= 1'b0;
            ex_op1      <= '0;
            ex_op2      <= '0;
            ex_op3      <= '0;
            ex_rd       <= '0;
            ex_wr_en    <= 1'b0;
            ex_mem_read <= 1'b0;
            ex_ctrl     <= '0;
        end else begin
            ex_valid    <= 1'b1;
            ex_op1      <= op_res[0];
            ex_op2      <= op_res[1];
            ex_op3      <= op_res[2];
            ex_rd       <= id_rd;
            ex_wr_en    <= id_wr_en;
            ex_mem_read <= id_mem_read;
            ex_ctrl     <= id_ctrl;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_bubbles <= '0;
            perf_fwd     <= '0;
        end else begin
            if (take_bubble && (perf_bubbles != 32'hFFFF_FFFF))
                perf_bubbles <= perf_bubbles + 32'd1;
            if (advance && id_valid && fwd_any && (perf_fwd != 32'hFFFF_FFFF))
                perf_fwd <= perf_fwd + 32'd1;
        end
    end
`else
    logic unused_fwd_any;
    assign unused_fwd_any = fwd_any;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_operand_stage
// Purpose  : Directed scenarios plus randomized traffic against a reference model.
// Revision : 1.0
// ============================================================================
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_rs1, id_rs2, id_rs3, id_rd;
    logic [2:0]  id_use;
    logic        id_wr_en, id_mem_read;
    logic [7:0]  id_ctrl;
    logic [31:0] rf_rd1, rf_rd2, rf_rd3;
    logic [3:0]  mem_rd, wb_rd;
    logic        mem_wr_en, mem_is_load, wb_wr_en;
    logic [31:0] mem_result, wb_data;
    logic        flush, ex_hold;
    logic        stall_id, ex_valid, ex_wr_en, ex_mem_read;
    logic [31:0] ex_op1, ex_op2, ex_op3;
    logic [3:0]  ex_rd;
    logic [7:0]  ex_ctrl;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] perf_bubbles, perf_fwd;
`endif

    id_ex_operand_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs3(id_rs3), .id_use(id_use),
        .id_rd(id_rd), .id_wr_en(id_wr_en), .id_mem_read(id_mem_read), .id_ctrl(id_ctrl),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .rf_rd3(rf_rd3),
        .mem_rd(mem_rd), .mem_wr_en(mem_wr_en), .mem_is_load(mem_is_load), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_wr_en(wb_wr_en), .wb_data(wb_data),
        .flush(flush), .ex_hold(ex_hold), .stall_id(stall_id), .ex_valid(ex_valid),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_op3(ex_op3), .ex_rd(ex_rd),
        .ex_wr_en(ex_wr_en), .ex_mem_read(ex_mem_read),
`ifdef ID_EX_PERF_CNT_EN
        .perf_bubbles(perf_bubbles), .perf_fwd(perf_fwd),
`endif
        .ex_ctrl(ex_ctrl)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model of the ID/EX contents
    logic        m_valid, m_wr, m_mr;
    logic [31:0] m_op [3];
    logic [3:0]  m_rd;
    logic [7:0]  m_ctrl;
    longint      m_bubbles, m_fwd;

    function automatic logic [3:0] src(input int i);
        return (i == 0) ? id_rs1 : (i == 1) ? id_rs2 : id_rs3;
    endfunction

    function automatic logic [31:0] rfv(input int i);
        return (i == 0) ? rf_rd1 : (i == 1) ? rf_rd2 : rf_rd3;
    endfunction

    function automatic bit real_reg(input logic [3:0] r);
        return (r >= 1) && (r <= 14);
    endfunction

    function automatic bit from_mem(input int i);
        return real_reg(src(i)) && mem_wr_en && !mem_is_load && mem_rd == src(i);
    endfunction

    function automatic bit from_wb(input int i);
        return real_reg(src(i)) && wb_wr_en && wb_rd == src(i);
    endfunction

    function automatic logic [31:0] resolve(input int i);
        if (from_mem(i)) return mem_result;
        if (from_wb(i))  return wb_data;
        return rfv(i);
    endfunction

    function automatic bit model_hazard();
        bit h = 0;
        if (!id_valid) return 0;
        for (int i = 0; i < 3; i++) begin
            if (id_use[i] && real_reg(src(i))) begin
                if (m_valid && m_wr && m_rd == src(i)) h = 1;
                if (mem_wr_en && mem_is_load && mem_rd == src(i)) h = 1;
            end
        end
        return h;
    endfunction

    task automatic model_clear_all();
        m_valid = 0; m_wr = 0; m_mr = 0; m_ctrl = 0; m_rd = 0;
        for (int i = 0; i < 3; i++) m_op[i] = 0;
    endtask

    task automatic model_update(input bit haz);
        bit any_fwd = 0;
        for (int i = 0; i < 3; i++) if (from_mem(i) || from_wb(i)) any_fwd = 1;
        if (rst) begin
            model_clear_all();
            m_bubbles = 0; m_fwd = 0;
        end else if (flush) begin
            m_valid = 0; m_wr = 0; m_mr = 0; m_ctrl = 0;
        end else if (ex_hold) begin
            // nothing moves
        end else if (haz) begin
            model_clear_all();
            if (m_bubbles < 64'hFFFF_FFFF) m_bubbles++;
        end else if (!id_valid) begin
            model_clear_all();
        end else begin
            m_valid = 1; m_wr = id_wr_en; m_mr = id_mem_read; m_ctrl = id_ctrl; m_rd = id_rd;
            for (int i = 0; i < 3; i++) m_op[i] = resolve(i);
            if (any_fwd && m_fwd < 64'hFFFF_FFFF) m_fwd++;
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge
    task automatic step();
        bit haz;
        #1;
        haz = model_hazard();
        check("stall_id", {63'd0, stall_id}, {63'd0, !rst && !flush && (ex_hold || haz)});
        @(posedge clk);
        model_update(haz);
        #1;
        check("ex_valid", {63'd0, ex_valid}, {63'd0, m_valid});
        check("ex_op1", {32'd0, ex_op1}, {32'd0, m_op[0]});
        check("ex_op2", {32'd0, ex_op2}, {32'd0, m_op[1]});
        check("ex_op3", {32'd0, ex_op3}, {32'd0, m_op[2]});
        check("ex_rd", {60'd0, ex_rd}, {60'd0, m_rd});
        check("ex_wr_en", {63'd0, ex_wr_en}, {63'd0, m_wr});
        check("ex_mem_read", {63'd0, ex_mem_read}, {63'd0, m_mr});
        check("ex_ctrl", {56'd0, ex_ctrl}, {56'd0, m_ctrl});
`ifdef ID_EX_PERF_CNT_EN
        check("perf_bubbles", {32'd0, perf_bubbles}, m_bubbles);
        check("perf_fwd", {32'd0, perf_fwd}, m_fwd);
`endif
        @(negedge clk);
    endtask

    task automatic quiet();
        rst = 0; flush = 0; ex_hold = 0;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs3 = 0; id_use = 0;
        id_rd = 0; id_wr_en = 0; id_mem_read = 0; id_ctrl = 0;
        rf_rd1 = 0; rf_rd2 = 0; rf_rd3 = 0;
        mem_rd = 0; mem_wr_en = 0; mem_is_load = 0; mem_result = 0;
        wb_rd = 0; wb_wr_en = 0; wb_data = 0;
    endtask

    function automatic logic [3:0] pick_reg();
        logic [3:0] tbl [6] = '{4'd0, 4'd3, 4'd5, 4'd7, 4'd15, 4'd9};
        return ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : tbl[$urandom_range(0, 5)];
    endfunction

    task automatic load_then_use();
        quiet();
        id_valid = 1; id_rd = 5; id_wr_en = 1; id_mem_read = 1; id_ctrl = 8'h4C;
        step();
        quiet();
        id_valid = 1; id_rs1 = 5; id_use = 3'b001; id_rd = 6; id_wr_en = 1; id_ctrl = 8'h21;
        rf_rd1 = 32'hDEAD;
        step();
        check("lu_bubble1_valid", {63'd0, ex_valid}, 64'd0);
        mem_rd = 5; mem_wr_en = 1; mem_is_load = 1;
    endtask

    logic [31:0] held_op1;

    initial begin
        model_clear_all();
        m_bubbles = 0; m_fwd = 0;
        quiet();
        rst = 1; id_valid = 1; id_ctrl = 8'hFF; rf_rd1 = 32'h99;
        @(negedge clk);
        step();
        check("rst_valid", {63'd0, ex_valid}, 64'd0);
        check("rst_op1", {32'd0, ex_op1}, 64'd0);

        // Plain capture
        quiet();
        id_valid = 1; id_rs1 = 1; id_rs2 = 2; id_rs3 = 4; id_use = 3'b111;
        id_rd = 9; id_ctrl = 8'h5A;
        rf_rd1 = 32'h11; rf_rd2 = 32'h22; rf_rd3 = 32'h33;
        step();
        check("basic_op1", {32'd0, ex_op1}, 64'h11);
        check("basic_op2", {32'd0, ex_op2}, 64'h22);
        check("basic_op3", {32'd0, ex_op3}, 64'h33);
        check("basic_valid", {63'd0, ex_valid}, 64'd1);

        // Forwarding priority
        quiet();
        id_valid = 1; id_rs1 = 3; id_use = 3'b001; id_rd = 9; rf_rd1 = 32'h77;
        mem_rd = 3; mem_wr_en = 1; mem_result = 32'hAAAA;
        wb_rd = 3; wb_wr_en = 1; wb_data = 32'hBBBB;
        step();
        check("fwd_mem_wins", {32'd0, ex_op1}, 64'hAAAA);
        mem_wr_en = 0;
        step();
        check("fwd_wb", {32'd0, ex_op1}, 64'hBBBB);
        id_rs1 = 0; wb_rd = 0;
        step();
        check("r0_no_fwd", {32'd0, ex_op1}, 64'h77);

        // Load-use: two bubbles then WB forward
        rst = 1; step();
        load_then_use();
        step();
        check("lu_bubble2_valid", {63'd0, ex_valid}, 64'd0);
        mem_wr_en = 0; mem_is_load = 0;
        wb_rd = 5; wb_wr_en = 1; wb_data = 32'h1234;
        step();
        check("lu_op1", {32'd0, ex_op1}, 64'h1234);
        check("lu_valid", {63'd0, ex_valid}, 64'd1);
`ifdef ID_EX_PERF_CNT_EN
        check("lu_perf_bubbles", {32'd0, perf_bubbles}, 64'd2);
        check("lu_perf_fwd", {32'd0, perf_fwd}, 64'd1);
`endif

        // id_use gating, then single ALU bubble
        quiet();
        id_valid = 1; id_rd = 7; id_wr_en = 1; step();
        id_rs2 = 7; id_use = 3'b101; id_rd = 8; id_wr_en = 0; step();
        check("unused_src_no_bubble", {63'd0, ex_valid}, 64'd1);
        id_rs2 = 0; id_use = 0; id_rd = 7; id_wr_en = 1; step();
        id_rs2 = 7; id_use = 3'b010; id_rd = 8; id_wr_en = 0; step();
        check("alu_bubble", {63'd0, ex_valid}, 64'd0);
        mem_rd = 7; mem_wr_en = 1; mem_result = 32'hCAFE; step();
        check("alu_fwd_op2", {32'd0, ex_op2}, 64'hCAFE);

        // Flush during second load-use bubble
        load_then_use();
        flush = 1; step();
        check("flush_valid", {63'd0, ex_valid}, 64'd0);

        // Hold for three cycles
        quiet();
        id_valid = 1; rf_rd1 = 32'h55; id_rd = 2; id_wr_en = 1; step();
        held_op1 = ex_op1;
        for (int k = 0; k < 3; k++) begin
            ex_hold = 1; rf_rd1 = $urandom; id_rd = 4'($urandom_range(1, 14));
            step();
            check("hold_op1", {32'd0, ex_op1}, {32'd0, held_op1});
        end

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 60) == 0);
            flush = ($urandom_range(0, 12) == 0);
            ex_hold = ($urandom_range(0, 9) == 0);
            id_valid = ($urandom_range(0, 7) != 0);
            id_rs1 = pick_reg(); id_rs2 = pick_reg(); id_rs3 = pick_reg();
            id_use = 3'($urandom); id_rd = pick_reg();
            id_wr_en = 1'($urandom); id_mem_read = ($urandom_range(0, 3) == 0);
            id_ctrl = 8'($urandom);
            rf_rd1 = $urandom; rf_rd2 = $urandom; rf_rd3 = $urandom;
            mem_rd = pick_reg(); mem_wr_en = 1'($urandom); mem_is_load = ($urandom_range(0, 2) == 0);
            mem_result = $urandom;
            wb_rd = pick_reg(); wb_wr_en = 1'($urandom); wb_data = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
